// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 core constants, opcodes and fetch types
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes decoded by the control unit
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FP     = 7'b1010011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x {pc,instr} synchronous FIFO with clear
// Ports: clk, rst (async active-high), clear (empties FIFO), push/push_data,
//        pop, head (oldest entry), count, empty, full.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves the same cycle
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction fetch stage and IF/ID pipeline register
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
// Ports: clk, rst (async active-high); imem_req/imem_ready/imem_addr request side;
//        imem_rvalid/imem_rdata in-order response side; stall_D, flush_D from decode;
//        redirect_E/redirect_pc_E from execute; instr_D, pc_D, pc_plus4_D, valid_D to decode.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        redirect_E,
    input  logic [31:0] redirect_pc_E,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc_plus4_D,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles,
`endif
    output logic        valid_D
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   pc_F;
    logic [31:0]   resp_pc;      // PC of the next response that will be kept
    logic [31:0]   target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  fifo_head;
    fetch_entry_t  resp_entry;

    logic issue;
    logic resp;
    logic accept;
    logic drop_now;
    logic load;
    logic pop;
    logic bypass;
    logic push;

    assign target = align_word(redirect_pc_E);

    // Credit check over in-flight requests plus buffered words keeps the FIFO from overflowing
    assign imem_req  = !rst && !redirect_E &&
                       ((int'(outstanding) + int'(fifo_count)) < BUF_DEPTH);
    assign imem_addr = pc_F;
    assign issue     = imem_req && imem_ready;

    // A response with nothing outstanding belongs to a request cut off by reset
    assign resp      = imem_rvalid && (outstanding != '0);
    assign drop_now  = resp && (drop_cnt != '0);
    assign accept    = resp && (drop_cnt == '0) && !redirect_E;

    assign load      = !redirect_E && !flush_D && !stall_D;
    assign pop       = load && !fifo_empty;
    assign bypass    = load && fifo_empty && accept;
    assign push      = accept && !bypass && (!fifo_full || pop);

    assign resp_entry = '{pc: resp_pc, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_E),
        .push      (push),
        .push_data (resp_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_F        <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (redirect_E) begin
                pc_F     <= target;
                resp_pc  <= target;
                // Everything still in flight after this cycle's response is stale
                drop_cnt <= outstanding - CW'(resp);
            end else begin
                if (issue)    pc_F     <= pc_F + 32'd4;
                if (accept)   resp_pc  <= resp_pc + 32'd4;
                if (drop_now) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_D <= 1'b0;
            instr_D <= NOP_INSTR;
            pc_D    <= '0;
        end else if (redirect_E || flush_D) begin
            valid_D <= 1'b0;
            instr_D <= NOP_INSTR;
        end else if (!stall_D) begin
            if (pop) begin
                valid_D <= 1'b1;
                instr_D <= fifo_head.instr;
                pc_D    <= fifo_head.pc;
            end else if (bypass) begin
                valid_D <= 1'b1;
                instr_D <= imem_rdata;
                pc_D    <= resp_pc;
            end else begin
                valid_D <= 1'b0;
                instr_D <= NOP_INSTR;
            end
        end
    end

    assign pc_plus4_D = pc_D + 32'd4;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (pop || bypass)             perf_fetched <= perf_fetched + 32'd1;
            if (!stall_D && !(pop || bypass)) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed/table-driven self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_D;
    logic        flush_D;
    logic        redirect_E;
    logic [31:0] redirect_pc_E;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc_plus4_D;
    logic        valid_D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall_D       (stall_D),
        .flush_D       (flush_D),
        .redirect_E    (redirect_E),
        .redirect_pc_E (redirect_pc_E),
        .instr_D       (instr_D),
        .pc_D          (pc_D),
        .pc_plus4_D    (pc_plus4_D),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles),
`endif
        .valid_D       (valid_D)
    );

    typedef struct {
        bit          stall;
        bit          flush;
        bit          redir;
        bit          ready;
        logic [31:0] rpc;
        bit          exp_req;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t        tbl [25];
    mreq_t       mq [$];
    int          n_vec;
    int          n_fail;
    int          edge_cnt;
    int          last_due;
    int          lat_min;
    int          lat_max;
    bit          stale_inject;
    bit          saw_req;
    logic [31:0] exp_pc;
    logic [31:0] d_pc;
    bit          d_valid;
    int          n_loads;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, model the memory, step past posedge
    task automatic cycle(input bit st, input bit fl, input bit rd,
                         input logic [31:0] rpc, input bit rdy);
        bit took_q;
        @(negedge clk);
        stall_D       = st;
        flush_D       = fl;
        redirect_E    = rd;
        redirect_pc_E = rpc;
        imem_ready    = rdy;
        took_q        = 1'b0;
        if (mq.size() > 0 && mq[0].due == edge_cnt + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            took_q      = 1'b1;
        end else if (stale_inject) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_BAD0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        saw_req = imem_req;
        if (imem_req && imem_ready) begin
            int d;
            d = edge_cnt + 1 + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{imem_addr, d});
            check32("outstanding_bound", (mq.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
        end
        @(posedge clk);
        edge_cnt++;
        if (took_q) void'(mq.pop_front());
        stale_inject = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        mq.delete();
        edge_cnt = 0;
        last_due = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_idle();
        stall_D       = 1'b0;
        flush_D       = 1'b0;
        redirect_E    = 1'b0;
        redirect_pc_E = '0;
        imem_ready    = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check32({tag, "_req"},    {31'b0, imem_req}, 32'd0);
        check32({tag, "_addr"},   imem_addr, 32'h0);
        check32({tag, "_valid"},  {31'b0, valid_D}, 32'd0);
        check32({tag, "_instr"},  instr_D, NOP);
        check32({tag, "_pc"},     pc_D, 32'h0);
        check32({tag, "_pc4"},    pc_plus4_D, 32'h4);
    endtask

    // Scoreboard step for the D register after one cycle with the given controls
    task automatic check_d(input bit st, input bit fl, input bit rd);
        if (rd || fl) begin
            check32("squash_valid", {31'b0, valid_D}, 32'd0);
            check32("squash_instr", instr_D, NOP);
            d_valid = 1'b0;
        end else if (st) begin
            check32("stall_valid", {31'b0, valid_D}, {31'b0, d_valid});
            if (d_valid) check32("stall_pc", pc_D, d_pc);
            else         check32("stall_instr", instr_D, NOP);
        end else if (valid_D) begin
            check32("seq_pc", pc_D, exp_pc);
            check32("seq_instr", instr_D, mem_word(exp_pc));
            check32("seq_pc4", pc_plus4_D, exp_pc + 32'd4);
            d_pc    = exp_pc;
            d_valid = 1'b1;
            exp_pc  = exp_pc + 32'd4;
            n_loads++;
        end else begin
            check32("bubble_instr", instr_D, NOP);
            d_valid = 1'b0;
        end
    endtask

    initial begin
        n_vec        = 0;
        n_fail       = 0;
        lat_min      = 1;
        lat_max      = 1;
        stale_inject = 1'b0;
        saw_req      = 1'b0;
        rst          = 1'b1;
        drive_idle();

        //           stall flush redir ready rpc          req valid pc
        tbl[0]  = '{0, 0, 0, 1, 32'h0,   1, 0, 32'h0};
        tbl[1]  = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h0};
        tbl[2]  = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h4};
        tbl[3]  = '{1, 0, 0, 1, 32'h0,   1, 1, 32'h4};
        tbl[4]  = '{1, 0, 0, 1, 32'h0,   0, 1, 32'h4};
        tbl[5]  = '{1, 0, 0, 1, 32'h0,   0, 1, 32'h4};
        tbl[6]  = '{1, 0, 0, 1, 32'h0,   0, 1, 32'h4};
        tbl[7]  = '{0, 0, 0, 1, 32'h0,   0, 1, 32'h8};
        tbl[8]  = '{0, 0, 0, 1, 32'h0,   1, 1, 32'hC};
        tbl[9]  = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h10};
        tbl[10] = '{1, 1, 0, 1, 32'h0,   1, 0, 32'h0};
        tbl[11] = '{0, 0, 0, 1, 32'h0,   0, 1, 32'h14};
        tbl[12] = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h18};
        tbl[13] = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h1C};
        tbl[14] = '{0, 0, 1, 1, 32'h103, 0, 0, 32'h0};
        tbl[15] = '{0, 0, 0, 1, 32'h0,   1, 0, 32'h0};
        tbl[16] = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h100};
        tbl[17] = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h104};
        tbl[18] = '{0, 0, 1, 1, 32'h200, 0, 0, 32'h0};
        tbl[19] = '{0, 0, 0, 1, 32'h0,   1, 0, 32'h0};
        tbl[20] = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h200};
        tbl[21] = '{0, 0, 0, 0, 32'h0,   1, 1, 32'h204};
        tbl[22] = '{0, 0, 0, 0, 32'h0,   1, 0, 32'h0};
        tbl[23] = '{0, 0, 0, 1, 32'h0,   1, 0, 32'h0};
        tbl[24] = '{0, 0, 0, 1, 32'h0,   1, 1, 32'h208};

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Table: 1-cycle memory, stall/flush/redirect corner cases
        release_reset();
        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].rpc, tbl[i].ready);
            check32($sformatf("v%0d_req", i), {31'b0, saw_req}, {31'b0, tbl[i].exp_req});
            check32($sformatf("v%0d_valid", i), {31'b0, valid_D}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                check32($sformatf("v%0d_pc", i), pc_D, tbl[i].exp_pc);
                check32($sformatf("v%0d_instr", i), instr_D, mem_word(tbl[i].exp_pc));
                check32($sformatf("v%0d_pc4", i), pc_plus4_D, tbl[i].exp_pc + 32'd4);
            end else begin
                check32($sformatf("v%0d_nop", i), instr_D, NOP);
            end
        end

        // Redirect with two requests in flight (3-cycle memory): both must be dropped
        rst = 1'b1;
        drive_idle();
        #2;
        release_reset();
        lat_min = 3;
        lat_max = 3;
        cycle(0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 32'h0, 1);
        check32("two_in_flight", mq.size(), 32'd2);
        cycle(0, 0, 1, 32'h100, 1);
        exp_pc  = 32'h100;
        d_valid = 1'b0;
        n_loads = 0;
        for (int i = 0; i < 20 && n_loads < 2; i++) begin
            cycle(0, 0, 0, 32'h0, 1);
            check_d(0, 0, 0);
        end
        check32("redirect_loads", n_loads, 32'd2);

        // Random ready, 1-3 cycle latency, occasional stall/flush/redirect
        lat_min = 1;
        lat_max = 3;
        n_loads = 0;
        for (int i = 0; i < 400; i++) begin
            bit          st;
            bit          fl;
            bit          rd;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            rd  = ($urandom_range(0, 29) == 0) || (i == 150);
            rpc = (i == 150) ? 32'hFFFF_FFF6 : ($urandom & 32'h0000_FFFF);
            cycle(st, fl, rd, rpc, 1'($urandom_range(0, 1)));
            check_d(st, fl, rd);
            if (rd) begin
                exp_pc = rpc & ~32'h3;
            end
        end
        check32("random_progress", (n_loads >= 30) ? 32'd1 : 32'd0, 32'd1);

        // Asynchronous reset in the middle of a burst
        cycle(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("midrst");
        drive_idle();
        release_reset();
        lat_min      = 1;
        lat_max      = 1;
        exp_pc       = 32'h0;
        d_valid      = 1'b0;
        n_loads      = 0;
        stale_inject = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 32'h0, 1);
            check_d(0, 0, 0);
        end
        check32("post_reset_loads", n_loads, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
